// File: rtl/cgp_eval_pkg.sv
// ----------------------------------------------------------------------------
// cgp_eval_pkg
// Shared definitions for the CGP truth-table evaluator: FSM state encoding,
// vector count, score width and truth-table width.
// Ports: none (package).
// ----------------------------------------------------------------------------
package cgp_eval_pkg;

    localparam int NUM_VEC = 16;
    localparam int SCORE_W = 7;
    localparam int TT_W    = 64;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

endpackage

// File: rtl/cgp_match_count.sv
// ----------------------------------------------------------------------------
// cgp_match_count
// Combinational 4-bit match counter: counts how many bits of the evolved
// circuit's outputs agree with the expected nibble (XNOR popcount).
// Ports:
//   observed_bits  in  4  outputs sampled from the evolved circuit
//   expected_bits  in  4  matching nibble of the target truth table
//   match_count    out 3  number of equal bit positions, 0..4
// ----------------------------------------------------------------------------
module cgp_match_count (
    input  logic [3:0] observed_bits,
    input  logic [3:0] expected_bits,
    output logic [2:0] match_count
);

    logic [3:0] equal_bits;

    assign equal_bits  = ~(observed_bits ^ expected_bits);
    assign match_count = {2'b00, equal_bits[0]} + {2'b00, equal_bits[1]}
                       + {2'b00, equal_bits[2]} + {2'b00, equal_bits[3]};

endmodule

// File: rtl/cgp_evaluator.sv
// ----------------------------------------------------------------------------
// cgp_evaluator
// Drives all 16 input vectors into an evolved 4-in/4-out CGP circuit, holds
// each vector for SETTLE_CYCLES clocks, samples the outputs for one cycle and
// accumulates the number of output bits matching a target truth table.
// Optional macro: CGP_EVAL_TRACE_EN adds the 'observed' port, a record of
// every sampled output nibble.
// Ports:
//   clk       in  1   clock
//   rst_n     in  1   asynchronous active-low reset
//   start     in  1   request one evaluation (accepted only in IDLE)
//   target    in  64  desired truth table, nibble v = outputs for vector v
//   dut_in    out 4   registered drive to the evolved circuit
//   dut_out   in  4   evolved circuit outputs
//   busy      out 1   evaluation in progress (includes the DONE cycle)
//   done      out 1   one-cycle completion pulse
//   score     out 7   matching output bits of the last evaluation, 0..64
//   perfect   out 1   score == 64
//   observed  out 64  (CGP_EVAL_TRACE_EN only) sampled outputs per vector
// ----------------------------------------------------------------------------
module cgp_evaluator
    import cgp_eval_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int NUM_IN        = 4,
    parameter int NUM_OUT       = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [TT_W-1:0]     target,
    output logic [3:0]          dut_in,
    input  logic [3:0]          dut_out,
    output logic                busy,
    output logic                done,
    output logic [SCORE_W-1:0]  score,
    output logic                perfect
`ifdef CGP_EVAL_TRACE_EN
    ,
    output logic [TT_W-1:0]     observed
`endif
);

    // Parameter legality is checked at elaboration; the datapath is sized
    // for exactly four inputs and four outputs.
    if (NUM_IN != 4) begin : g_bad_num_in
        $error("cgp_evaluator: NUM_IN must be 4");
    end
    if (NUM_OUT != 4) begin : g_bad_num_out
        $error("cgp_evaluator: NUM_OUT must be 4");
    end
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("cgp_evaluator: SETTLE_CYCLES must be in 1..255");
    end

    localparam logic [7:0]         SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0]         LAST_VEC    = 4'(NUM_VEC - 1);
    localparam logic [SCORE_W-1:0] FULL_SCORE  = SCORE_W'(TT_W);

    state_t              state;
    state_t              state_nxt;
    logic [TT_W-1:0]     target_q;
    logic [SCORE_W-1:0]  acc;
    logic [SCORE_W-1:0]  acc_sum;
    logic [3:0]          vec;
    logic [7:0]          settle_cnt;
    logic [2:0]          match;

    // The nibble index {vec, 2'b00} selects the expected outputs for vec.
    cgp_match_count u_match (
        .observed_bits (dut_out),
        .expected_bits (target_q[{vec, 2'b00} +: 4]),
        .match_count   (match)
    );

    // At most 16 * 4 = 64 is ever added, so 7 bits cannot overflow.
    assign acc_sum = acc + {4'b0000, match};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                busy = 1'b1;
                if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                busy = 1'b1;
                if (vec == LAST_VEC) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = SETTLE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Score and perfect are loaded on the final SAMPLE edge so they are
    // already valid during the DONE cycle, and hold until the next run ends.
    // The settle counter is cleared when leaving SETTLE so every vector gets
    // the same hold time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q   <= '0;
            acc        <= '0;
            vec        <= '0;
            settle_cnt <= '0;
            dut_in     <= '0;
            score      <= '0;
            perfect    <= 1'b0;
`ifdef CGP_EVAL_TRACE_EN
            observed   <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        target_q   <= target;
                        acc        <= '0;
                        vec        <= '0;
                        settle_cnt <= '0;
                        dut_in     <= '0;
`ifdef CGP_EVAL_TRACE_EN
                        observed   <= '0;
`endif
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                SAMPLE: begin
                    acc <= acc_sum;
`ifdef CGP_EVAL_TRACE_EN
                    observed[{vec, 2'b00} +: 4] <= dut_out;
`endif
                    if (vec == LAST_VEC) begin
                        score   <= acc_sum;
                        perfect <= (acc_sum == FULL_SCORE);
                    end else begin
                        vec    <= vec + 4'd1;
                        dut_in <= vec + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cgp_evaluator.sv
// ----------------------------------------------------------------------------
// tb_cgp_evaluator
// Self-checking bench for cgp_evaluator. The evolved circuit is modelled as
// dut_out = dut_in ^ out_xor (out_xor = 0 is plain loopback). Expected
// results are pushed to a scoreboard when a run is started and popped when
// done pulses. Define CGP_EVAL_TRACE_EN for the bench and the RTL together.
// ----------------------------------------------------------------------------
module tb_cgp_evaluator;
    import cgp_eval_pkg::*;

    localparam int SETTLE  = 4;
    localparam int RUN_LAT = NUM_VEC * (SETTLE + 1);

    typedef struct {
        logic [SCORE_W-1:0] score;
        logic               perfect;
        int                 accept;
        logic [TT_W-1:0]    obs;
    } exp_t;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [TT_W-1:0]    target;
    logic [3:0]         dut_in;
    logic [3:0]         dut_out;
    logic               busy;
    logic               done;
    logic [SCORE_W-1:0] score;
    logic               perfect;
    logic [3:0]         out_xor;
`ifdef CGP_EVAL_TRACE_EN
    logic [TT_W-1:0]    observed;
`endif

    exp_t sb[$];
    int   errors     = 0;
    int   checks     = 0;
    int   cycle      = 0;
    int   done_count = 0;
    int   push_count = 0;
    logic prev_done  = 1'b0;

    assign dut_out = dut_in ^ out_xor;

    cgp_evaluator #(
        .SETTLE_CYCLES (SETTLE),
        .NUM_IN        (4),
        .NUM_OUT       (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .target   (target),
        .dut_in   (dut_in),
        .dut_out  (dut_out),
        .busy     (busy),
        .done     (done),
        .score    (score),
        .perfect  (perfect)
`ifdef CGP_EVAL_TRACE_EN
        ,
        .observed (observed)
`endif
    );

    // Free-running clock and a cycle counter used to measure latency.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic int modelScore(input logic [TT_W-1:0] t, input logic [3:0] x);
        int         s;
        logic [3:0] o;
        logic [3:0] want;
        s = 0;
        for (int v = 0; v < NUM_VEC; v++) begin
            o    = 4'(v) ^ x;
            want = t[v*4 +: 4];
            for (int b = 0; b < 4; b++) begin
                if (o[b] == want[b]) s++;
            end
        end
        return s;
    endfunction

    function automatic logic [TT_W-1:0] modelObs(input logic [3:0] x);
        logic [TT_W-1:0] r;
        r = '0;
        for (int v = 0; v < NUM_VEC; v++) r[v*4 +: 4] = 4'(v) ^ x;
        return r;
    endfunction

    function automatic exp_t makeExp(input logic [TT_W-1:0] t, input logic [3:0] x,
                                     input int accept);
        exp_t e;
        e.score   = SCORE_W'(modelScore(t, x));
        e.perfect = (modelScore(t, x) == 64);
        e.accept  = accept;
        e.obs     = modelObs(x);
        return e;
    endfunction

    // Scoreboard consumer: every done pulse pops one expected result and
    // checks score, perfect, latency from the accept edge and pulse width.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            done_count++;
            checkOutput("done_pulse_width", 64'(prev_done), 64'(0));
            checkOutput("done_expected", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checkOutput("score", 64'(score), 64'(e.score));
                checkOutput("perfect", 64'(perfect), 64'(e.perfect));
                checkOutput("latency", 64'(cycle - e.accept), 64'(RUN_LAT));
`ifdef CGP_EVAL_TRACE_EN
                checkOutput("observed", observed, e.obs);
`endif
            end
        end
        prev_done = done;
    end

    task automatic waitIdle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy) checkOutput("idle_timeout", 64'(busy), 64'(0));
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checkOutput("done_timeout", 64'(sb.size()), 64'(0));
            sb.delete();
        end
        @(negedge clk);
    endtask

    // Start one evaluation and push its expected result; returns the
    // accept-edge cycle number.
    task automatic applyStimulus(input logic [TT_W-1:0] t, input logic [3:0] x,
                                 output int accept);
        waitIdle(RUN_LAT + 20);
        @(negedge clk);
        target  = t;
        out_xor = x;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        accept = cycle;
        sb.push_back(makeExp(t, x, accept));
        push_count++;
    endtask

    initial begin
        int              acc_cyc;
        int              n;
        logic [TT_W-1:0] t;
        logic [3:0]      x;

        rst_n   = 1'b0;
        start   = 1'b0;
        target  = '0;
        out_xor = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_dut_in", 64'(dut_in), 64'(0));
        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_done", 64'(done), 64'(0));
        checkOutput("reset_score", 64'(score), 64'(0));
        checkOutput("reset_perfect", 64'(perfect), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Loopback patterns: perfect, half, and inverse truth tables.
        applyStimulus(64'hFEDCBA9876543210, 4'h0, acc_cyc);
        waitDrain(RUN_LAT + 20);
        repeat (5) @(negedge clk);
        checkOutput("dut_in_hold", 64'(dut_in), 64'(15));
        checkOutput("busy_after_done", 64'(busy), 64'(0));

        applyStimulus(64'h0, 4'h0, acc_cyc);
        waitDrain(RUN_LAT + 20);
        applyStimulus(64'h0123456789ABCDEF, 4'h0, acc_cyc);
        waitDrain(RUN_LAT + 20);

        // Non-trivial circuits against random truth tables.
        for (int i = 0; i < 4; i++) begin
            t = {$urandom, $urandom};
            x = 4'($urandom_range(0, 15));
            applyStimulus(t, x, acc_cyc);
            waitDrain(RUN_LAT + 20);
        end

        // Start pulses mid-run must neither restart nor queue a run.
        applyStimulus(64'hFEDCBA9876543210, 4'h0, acc_cyc);
        while (cycle < acc_cyc + 10) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cycle < acc_cyc + 40) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDrain(RUN_LAT + 20);
        repeat (RUN_LAT + 10) @(negedge clk);
        checkOutput("ignored_start_dones", 64'(done_count), 64'(push_count));

        // Target changes during a run must not affect the result.
        applyStimulus(64'h0F1E2D3C4B5A6978, 4'h3, acc_cyc);
        repeat (20) @(negedge clk);
        target = 64'hF0E1D2C3B4A59687;
        repeat (30) @(negedge clk);
        target = 64'h0;
        waitDrain(RUN_LAT + 20);

        // Start held high: two back-to-back runs with one IDLE cycle between.
        waitIdle(RUN_LAT + 20);
        @(negedge clk);
        target  = 64'hFEDCBA9876543210;
        out_xor = 4'h5;
        start   = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = cycle;
        sb.push_back(makeExp(64'hFEDCBA9876543210, 4'h5, acc_cyc));
        sb.push_back(makeExp(64'hFEDCBA9876543210, 4'h5, acc_cyc + RUN_LAT + 2));
        push_count += 2;
        repeat (RUN_LAT + 2) @(posedge clk);
        #1;
        start = 1'b0;
        waitDrain(2 * RUN_LAT + 40);

        // Reset during vector 7 aborts with no done and clears outputs.
        applyStimulus(64'hFEDCBA9876543210, 4'h0, acc_cyc);
        n = 0;
        while (dut_in != 4'd7 && n < RUN_LAT) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reached_vec7", 64'(dut_in), 64'(7));
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        push_count--;
        checkOutput("abort_dut_in", 64'(dut_in), 64'(0));
        checkOutput("abort_busy", 64'(busy), 64'(0));
        checkOutput("abort_done", 64'(done), 64'(0));
        checkOutput("abort_score", 64'(score), 64'(0));
        checkOutput("abort_perfect", 64'(perfect), 64'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (RUN_LAT + 10) @(negedge clk);
        checkOutput("abort_no_done", 64'(done_count), 64'(push_count));

        applyStimulus(64'hFEDCBA9876543210, 4'h0, acc_cyc);
        waitDrain(RUN_LAT + 20);

        repeat (20) @(negedge clk);
        checkOutput("total_dones", 64'(done_count), 64'(push_count));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
